// File: rtl/uart_pkg.sv
// Shared UART definitions for uart_rx and uart_tx: FSM state encoding, frame constants
// and baud divider derivation.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int   DATA_BITS   = 8;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

    function automatic int baud_div(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

    function automatic int half_div(input int clk_freq, input int baud_rate);
        return baud_div(clk_freq, baud_rate) / 2;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for asynchronous single-bit inputs (serial lines, buttons,
// switches); RESET_VALUE sets what both flops hold during reset.
module sync_2ff #(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VALUE;
            q    <= RESET_VALUE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit start validation, centre sampling, stop-bit check.
// Define UART_RX_MAJORITY_EN to take each decision from a 2-of-3 majority of the last three samples.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 20_000_000,
    parameter int BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam int          BAUD_DIV  = baud_div(CLK_FREQ, BAUD_RATE);
    localparam int          HALF_DIV  = half_div(CLK_FREQ, BAUD_RATE);
    localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
    localparam logic [15:0] HALF_LAST = 16'(HALF_DIV - 1);
    localparam logic [3:0]  LAST_BIT  = 4'(DATA_BITS - 1);

    uart_state_t state, state_d;
    logic [15:0] cnt, cnt_d;
    logic [3:0]  bit_idx, bit_idx_d;
    logic [7:0]  shreg, shreg_d;
    logic [7:0]  rx_data_d;
    logic        valid_d, err_d;
    logic        rx_s, rx_prev, sample;

    sync_2ff #(.RESET_VALUE(1'b1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rx_s)
    );

`ifdef UART_RX_MAJORITY_EN
    // The two previous samples line up with cnt==k-2 and k-1 whenever a decision is taken at k.
    logic [1:0] hist;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) hist <= 2'b11;
        else        hist <= {hist[0], rx_s};
    end

    assign sample = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
`else
    assign sample = rx_s;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            rx_prev   <= 1'b1;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            bit_idx   <= bit_idx_d;
            shreg     <= shreg_d;
            rx_data   <= rx_data_d;
            rx_valid  <= valid_d;
            frame_err <= err_d;
            rx_prev   <= rx_s;
        end
    end

    // A start needs a 1->0 transition, so a line stuck low after a break never re-triggers.
    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        bit_idx_d = bit_idx;
        shreg_d   = shreg;
        rx_data_d = rx_data;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        case (state)
            IDLE: begin
                cnt_d     = '0;
                bit_idx_d = '0;
                if (rx_prev && !rx_s) state_d = START;
            end
            START: begin
                if (cnt == HALF_LAST) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = (sample == START_LEVEL) ? DATA : IDLE;
                end else begin
                    cnt_d = cnt + 16'd1;
                end
            end
            DATA: begin
                if (cnt == BAUD_LAST) begin
                    cnt_d     = '0;
                    shreg_d   = {sample, shreg[7:1]};
                    bit_idx_d = bit_idx + 4'd1;
                    if (bit_idx == LAST_BIT) state_d = STOP;
                end else begin
                    cnt_d = cnt + 16'd1;
                end
            end
            STOP: begin
                if (cnt == BAUD_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    if (sample == STOP_LEVEL) begin
                        rx_data_d = shreg;
                        valid_d   = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: serial frames driven from tasks, received bytes
// compared against a queue of expected bytes.
module tb_uart_rx;

    localparam int CLK_FREQ  = 20_000_000;
    localparam int BAUD_RATE = 115200;
    localparam int B         = 173;
    localparam int HALF      = 86;
    localparam int LATENCY   = 2 + HALF + 9 * B;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       rx_busy;

    int check_count = 0;
    int pass_count  = 0;
    int cyc         = 0;
    int err_cnt     = 0;
    int both_cnt    = 0;
    int t0          = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         got_cyc_q[$];

    uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .rx_busy   (rx_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid) begin
                got_q.push_back(rx_data);
                got_cyc_q.push_back(cyc);
            end
            if (frame_err) err_cnt++;
            if (rx_valid && frame_err) both_cnt++;
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got %0d checks, required completion", check_count);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input int n);
        rx = v;
        wait_cycles(n);
    endtask

    task automatic send_frame(input logic [7:0] b, input int bc, input logic stop_v);
        t0 = cyc + 1;
        drive(1'b0, bc);
        for (int i = 0; i < 8; i++) drive(b[i], bc);
        drive(stop_v, bc);
    endtask

    task automatic clear_scoreboard();
        exp_q.delete();
        got_q.delete();
        got_cyc_q.delete();
        err_cnt = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rx    = 1'b1;
        wait_cycles(3);
        check_count++;
        if (rx_data !== 8'h00) $display("[TB] FAIL reset_rx_data: got %h, expected 00", rx_data);
        else pass_count++;
        check_count++;
        if ({rx_valid, frame_err, rx_busy} !== 3'b000)
            $display("[TB] FAIL reset_flags: got %b, expected 000", {rx_valid, frame_err, rx_busy});
        else pass_count++;
        rst_n = 1'b1;
        wait_cycles(5);
    endtask

    task automatic test_single();
        int got_cyc;
        logic [7:0] got, expv;
        clear_scoreboard();
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, B, 1'b1);
        wait_cycles(B);
        check_count++;
        if (got_q.size() != 1) $display("[TB] FAIL single_count: got %0d pulses, expected 1", got_q.size());
        else pass_count++;
        if (got_q.size() > 0) begin
            got     = got_q.pop_front();
            got_cyc = got_cyc_q.pop_front();
            expv    = exp_q.pop_front();
            check_count++;
            if (got !== expv) $display("[TB] FAIL single_data: got %h, expected %h", got, expv);
            else pass_count++;
            check_count++;
            if (got_cyc != t0 + LATENCY)
                $display("[TB] FAIL single_latency: got %0d, expected %0d", got_cyc - t0, LATENCY);
            else pass_count++;
        end
        check_count++;
        if (err_cnt != 0) $display("[TB] FAIL single_err: got %0d, expected 0", err_cnt);
        else pass_count++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] pattern [3];
        logic [7:0] got, expv;
        pattern = '{8'h00, 8'hFF, 8'h55};
        clear_scoreboard();
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(pattern[i]);
            send_frame(pattern[i], B, 1'b1);
        end
        wait_cycles(B);
        check_count++;
        if (got_q.size() != 3) $display("[TB] FAIL b2b_count: got %0d pulses, expected 3", got_q.size());
        else pass_count++;
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            got  = got_q.pop_front();
            expv = exp_q.pop_front();
            check_count++;
            if (got !== expv) $display("[TB] FAIL b2b_data: got %h, expected %h", got, expv);
            else pass_count++;
        end
        check_count++;
        if (err_cnt != 0) $display("[TB] FAIL b2b_err: got %0d, expected 0", err_cnt);
        else pass_count++;
    endtask

    task automatic test_glitch();
        int busy = 0;
        clear_scoreboard();
        rx = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            if (i == 39) rx = 1'b1;
            if (rx_busy) busy++;
        end
        check_count++;
        if (busy < 84 || busy > 90) $display("[TB] FAIL glitch_busy: got %0d cycles, expected 84..90", busy);
        else pass_count++;
        check_count++;
        if (got_q.size() != 0 || err_cnt != 0)
            $display("[TB] FAIL glitch_pulses: got valid=%0d err=%0d, expected 0 0", got_q.size(), err_cnt);
        else pass_count++;
    endtask

    task automatic test_break();
        logic [7:0] got;
        clear_scoreboard();
        send_frame(8'h3C, B, 1'b0);
        drive(1'b0, 3 * 10 * B);
        drive(1'b1, 2 * B);
        check_count++;
        if (err_cnt != 1) $display("[TB] FAIL break_err_count: got %0d, expected 1", err_cnt);
        else pass_count++;
        check_count++;
        if (got_q.size() != 0) $display("[TB] FAIL break_valid: got %0d pulses, expected 0", got_q.size());
        else pass_count++;
        check_count++;
        if (rx_data !== 8'h55) $display("[TB] FAIL break_hold: got %h, expected 55", rx_data);
        else pass_count++;
        exp_q.push_back(8'h81);
        send_frame(8'h81, B, 1'b1);
        wait_cycles(B);
        check_count++;
        if (got_q.size() != 1) begin
            $display("[TB] FAIL break_recover_count: got %0d pulses, expected 1", got_q.size());
        end else begin
            got = got_q.pop_front();
            if (got !== exp_q[0]) $display("[TB] FAIL break_recover_data: got %h, expected %h", got, exp_q[0]);
            else pass_count++;
        end
        check_count++;
        if (err_cnt != 1) $display("[TB] FAIL break_err_final: got %0d, expected 1", err_cnt);
        else pass_count++;
    endtask

    task automatic test_baud_offset();
        int rates [2];
        logic [7:0] got;
        rates = '{168, 178};
        for (int r = 0; r < 2; r++) begin
            clear_scoreboard();
            exp_q.push_back(8'hC3);
            send_frame(8'hC3, rates[r], 1'b1);
            drive(1'b1, B);
            check_count++;
            if (got_q.size() != 1 || err_cnt != 0) begin
                $display("[TB] FAIL baud_%0d_count: got valid=%0d err=%0d, expected 1 0", rates[r], got_q.size(), err_cnt);
            end else begin
                got = got_q.pop_front();
                if (got !== exp_q[0]) $display("[TB] FAIL baud_%0d_data: got %h, expected %h", rates[r], got, exp_q[0]);
                else pass_count++;
            end
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] b = 8'h12;
        logic [7:0] got;
        clear_scoreboard();
        drive(1'b0, B);
        for (int i = 0; i < 4; i++) drive(b[i], B);
        drive(b[4], 80);
        rst_n = 1'b0;
        rx    = 1'b1;
        wait_cycles(4);
        check_count++;
        if (rx_data !== 8'h00) $display("[TB] FAIL abort_rx_data: got %h, expected 00", rx_data);
        else pass_count++;
        check_count++;
        if ({rx_valid, frame_err, rx_busy} !== 3'b000)
            $display("[TB] FAIL abort_flags: got %b, expected 000", {rx_valid, frame_err, rx_busy});
        else pass_count++;
        rst_n = 1'b1;
        wait_cycles(2 * B);
        check_count++;
        if (got_q.size() != 0 || err_cnt != 0)
            $display("[TB] FAIL abort_pulses: got valid=%0d err=%0d, expected 0 0", got_q.size(), err_cnt);
        else pass_count++;
        exp_q.push_back(8'h12);
        send_frame(8'h12, B, 1'b1);
        wait_cycles(B);
        check_count++;
        if (got_q.size() != 1) begin
            $display("[TB] FAIL abort_recover_count: got %0d pulses, expected 1", got_q.size());
        end else begin
            got = got_q.pop_front();
            if (got !== exp_q[0]) $display("[TB] FAIL abort_recover_data: got %h, expected %h", got, exp_q[0]);
            else pass_count++;
        end
    endtask

`ifdef UART_RX_MAJORITY_EN
    task automatic test_majority();
        logic [9:0] frame;
        int got_cyc;
        logic [7:0] got;
        clear_scoreboard();
        frame = {1'b1, 8'h6E, 1'b0};
        exp_q.push_back(8'h6E);
        t0 = cyc + 1;
        for (int i = 0; i < 10; i++) begin
            drive(frame[i], HALF);
            drive(~frame[i], 1);
            drive(frame[i], B - HALF - 1);
        end
        wait_cycles(B);
        check_count++;
        if (got_q.size() != 1 || err_cnt != 0) begin
            $display("[TB] FAIL majority_count: got valid=%0d err=%0d, expected 1 0", got_q.size(), err_cnt);
        end else begin
            got     = got_q.pop_front();
            got_cyc = got_cyc_q.pop_front();
            if (got !== exp_q[0]) $display("[TB] FAIL majority_data: got %h, expected %h", got, exp_q[0]);
            else if (got_cyc != t0 + LATENCY)
                $display("[TB] FAIL majority_latency: got %0d, expected %0d", got_cyc - t0, LATENCY);
            else pass_count++;
        end
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        rx    = 1'b1;
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_break();
        test_baud_offset();
        test_reset_midframe();
`ifdef UART_RX_MAJORITY_EN
        test_majority();
`endif
        check_count++;
        if (both_cnt != 0) $display("[TB] FAIL exclusive_pulses: got %0d overlaps, expected 0", both_cnt);
        else pass_count++;
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
